// File: rtl/fetch_pc_stage.sv
// Fetch stage: owns the PC, issues 1-cycle-latency imem reads and buffers {pc, insn} in a 2-entry skid FIFO.
// Define FETCH_STATS_EN to add fetch_count_o, a wrapping count of instructions handed to decode.
module fetch_pc_stage #(
    parameter int unsigned       DWIDTH   = 32,
    parameter int unsigned       AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(32'h0100_0000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              imem_req_o,
    output logic [AWIDTH-1:0] imem_addr_o,
    input  logic [DWIDTH-1:0] imem_rdata_i,
    output logic              insn_valid_o,
    input  logic              insn_ready_i,
    output logic [AWIDTH-1:0] insn_pc_o,
`ifdef FETCH_STATS_EN
    output logic [31:0]       fetch_count_o,
`endif
    output logic [DWIDTH-1:0] insn_o
);

    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [AWIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        count_q, count_d;
    logic              head_q, head_d;
    logic [AWIDTH-1:0] fifo_pc_q [2];
    logic [AWIDTH-1:0] fifo_pc_d [2];
    logic [DWIDTH-1:0] fifo_insn_q [2];
    logic [DWIDTH-1:0] fifo_insn_d [2];

    logic       pop;
    logic       push;
    logic       issue;
    logic       tail;
    logic [1:0] credit_used;
    logic       redirect_lsb_unused;

    assign redirect_lsb_unused = ^redirect_pc_i[1:0];

    assign pop         = (count_q != 2'd0) && insn_ready_i;
    assign push        = inflight_q && !redirect_i;
    assign tail        = head_q ^ count_q[0];
    // Entries held plus the response still on its way must leave room for a new word.
    assign credit_used = count_q + 2'(inflight_q) - 2'(pop);
    assign issue       = !rst && !redirect_i && (credit_used < 2'd2);

    always_comb begin
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue;
        count_d       = count_q;
        head_d        = head_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_insn_d   = fifo_insn_q;

        if (issue) begin
            pc_d          = pc_q + AWIDTH'(4);
            inflight_pc_d = pc_q;
        end

        if (redirect_i) begin
            pc_d    = {redirect_pc_i[AWIDTH-1:2], 2'b00};
            count_d = 2'd0;
            head_d  = head_q ^ pop;
        end else begin
            if (pop) begin
                head_d = ~head_q;
            end
            if (push) begin
                fifo_pc_d[tail]   = inflight_pc_q;
                fifo_insn_d[tail] = imem_rdata_i;
            end
            count_d = count_q + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            count_q       <= 2'd0;
            head_q        <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_pc_q[i]   <= '0;
                fifo_insn_q[i] <= '0;
            end
        end else begin
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            count_q       <= count_d;
            head_q        <= head_d;
            fifo_pc_q     <= fifo_pc_d;
            fifo_insn_q   <= fifo_insn_d;
        end
    end

    assign imem_req_o   = issue;
    assign imem_addr_o  = pc_q;
    assign insn_valid_o = (count_q != 2'd0);
    assign insn_pc_o    = fifo_pc_q[head_q];
    assign insn_o       = fifo_insn_q[head_q];

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    // A pop in a redirect cycle still counts: decode really consumed that head.
    always_comb begin
        fetch_count_d = fetch_count_q + 32'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count_o = fetch_count_q;
`endif

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Self-checking bench for fetch_pc_stage: cycle table for start-up/backpressure plus a {pc, insn} scoreboard.
module tb_fetch_pc_stage;

    localparam logic [31:0] RESET_PC = 32'h0100_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        insn_valid_o;
    logic        insn_ready_i;
    logic [31:0] insn_pc_o;
    logic [31:0] insn_o;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count_o;
`endif

    fetch_pc_stage dut (
        .clk          (clk),
        .rst          (rst),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_rdata_i (imem_rdata_i),
        .insn_valid_o (insn_valid_o),
        .insn_ready_i (insn_ready_i),
        .insn_pc_o    (insn_pc_o),
`ifdef FETCH_STATS_EN
        .fetch_count_o(fetch_count_o),
`endif
        .insn_o       (insn_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: word returned one cycle after the address is presented.
    always @(posedge clk) imem_rdata_i <= imem_addr_o ^ KEY;

    typedef struct {
        logic        rst;
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } sb_t;

    vec_t vecs [14];
    sb_t  expQ [$];
    int   total;
    int   bad;
    int   popCount;
    int   popBase;
    int   mark;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic setVec(input int idx, input logic r, input logic rdy, input logic req,
                          input logic [31:0] addr, input logic vld, input logic [31:0] pc);
        vecs[idx].rst   = r;
        vecs[idx].ready = rdy;
        vecs[idx].req   = req;
        vecs[idx].addr  = addr;
        vecs[idx].valid = vld;
        vecs[idx].pc    = pc;
    endtask

    task automatic fillQueue(input logic [31:0] start);
        logic [31:0] pc;
        pc = start;
        expQ.delete();
        for (int i = 0; i < 64; i++) begin
            expQ.push_back({pc, pc ^ KEY});
            pc = pc + 32'd4;
        end
    endtask

    task automatic sbCheck();
        sb_t e;
        if (!rst && insn_valid_o && insn_ready_i) begin
            popCount++;
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL sb_empty: got pc %h with nothing expected", insn_pc_o);
            end else begin
                e = expQ.pop_front();
                checkOutput("sb_pc", insn_pc_o, e.pc);
                checkOutput("sb_insn", insn_o, e.insn);
            end
        end
    endtask

    task automatic toNegedge();
        @(negedge clk);
        sbCheck();
    endtask

    task automatic toNextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            toNegedge();
            toNextCycle();
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rdy, input logic redir, input logic [31:0] rpc);
        rst           = r;
        insn_ready_i  = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
    endtask

    // Called at a negedge; leaves the bench at the negedge where valid is seen.
    task automatic waitValid(input int maxCycles, input string name);
        int n;
        n = 0;
        while (!insn_valid_o && n < maxCycles) begin
            toNextCycle();
            toNegedge();
            n++;
        end
        checkOutput(name, 32'(insn_valid_o), 32'd1);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        popCount = 0;
        popBase  = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        repeat (2) @(posedge clk);
        #1;

        //        idx rst rdy req  addr                 vld  pc
        setVec(0,  1, 1, 0, RESET_PC,            0, 32'h0);
        setVec(1,  0, 1, 1, 32'h0100_0000,       0, 32'h0);
        setVec(2,  0, 1, 1, 32'h0100_0004,       0, 32'h0);
        setVec(3,  0, 1, 1, 32'h0100_0008,       1, 32'h0100_0000);
        setVec(4,  0, 1, 1, 32'h0100_000C,       1, 32'h0100_0004);
        setVec(5,  0, 1, 1, 32'h0100_0010,       1, 32'h0100_0008);
        setVec(6,  0, 0, 0, 32'h0100_0014,       1, 32'h0100_000C);
        setVec(7,  0, 0, 0, 32'h0100_0014,       1, 32'h0100_000C);
        setVec(8,  0, 0, 0, 32'h0100_0014,       1, 32'h0100_000C);
        setVec(9,  0, 0, 0, 32'h0100_0014,       1, 32'h0100_000C);
        setVec(10, 0, 0, 0, 32'h0100_0014,       1, 32'h0100_000C);
        setVec(11, 0, 1, 1, 32'h0100_0014,       1, 32'h0100_000C);
        setVec(12, 0, 1, 1, 32'h0100_0018,       1, 32'h0100_0010);
        setVec(13, 0, 1, 1, 32'h0100_001C,       1, 32'h0100_0014);

        fillQueue(RESET_PC);
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].ready, 1'b0, 32'd0);
            toNegedge();
            checkOutput($sformatf("v%0d_req", i), 32'(imem_req_o), 32'(vecs[i].req));
            checkOutput($sformatf("v%0d_addr", i), imem_addr_o, vecs[i].addr);
            checkOutput($sformatf("v%0d_valid", i), 32'(insn_valid_o), 32'(vecs[i].valid));
            checkOutput($sformatf("v%0d_pc", i), insn_pc_o, vecs[i].pc);
            checkOutput($sformatf("v%0d_insn", i), insn_o, vecs[i].valid ? (vecs[i].pc ^ KEY) : 32'h0);
            toNextCycle();
        end

        // Redirect with one buffered entry and one response in flight, decode stalled.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0100_0203);
        toNegedge();
        checkOutput("redir_req", 32'(imem_req_o), 32'd0);
        toNextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        fillQueue(32'h0100_0200);
        toNegedge();
        checkOutput("redir_valid", 32'(insn_valid_o), 32'd0);
        checkOutput("redir_addr", imem_addr_o, 32'h0100_0200);
        checkOutput("redir_newreq", 32'(imem_req_o), 32'd1);
        toNextCycle();
        toNegedge();
        checkOutput("redir_valid2", 32'(insn_valid_o), 32'd0);
        toNextCycle();
        toNegedge();
        checkOutput("redir_first_valid", 32'(insn_valid_o), 32'd1);
        checkOutput("redir_first_pc", insn_pc_o, 32'h0100_0200);
        toNextCycle();
        stream(3);

        // Redirect in the same cycle decode pops the head.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0100_0400);
        mark = popCount;
        toNegedge();
        checkOutput("popredir_popped", 32'(popCount - mark), 32'd1);
        toNextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        fillQueue(32'h0100_0400);
        toNegedge();
        checkOutput("popredir_flushed", 32'(insn_valid_o), 32'd0);
`ifdef FETCH_STATS_EN
        checkOutput("popredir_count", fetch_count_o, 32'(popCount - popBase));
`endif
        waitValid(6, "popredir_timeout");
        checkOutput("popredir_pc", insn_pc_o, 32'h0100_0400);
        toNextCycle();
        stream(3);

        // Fill the FIFO under backpressure, then reset mid-run.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        stream(2);
        toNegedge();
        checkOutput("full_valid", 32'(insn_valid_o), 32'd1);
        checkOutput("full_req", 32'(imem_req_o), 32'd0);
        toNextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        toNegedge();
        toNextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        fillQueue(RESET_PC);
        popBase = popCount;
        toNegedge();
        checkOutput("rst_valid", 32'(insn_valid_o), 32'd0);
        checkOutput("rst_pc", insn_pc_o, 32'h0);
        checkOutput("rst_insn", insn_o, 32'h0);
        checkOutput("rst_req", 32'(imem_req_o), 32'd1);
        checkOutput("rst_addr", imem_addr_o, RESET_PC);
`ifdef FETCH_STATS_EN
        checkOutput("rst_count", fetch_count_o, 32'd0);
`endif
        waitValid(6, "rst_timeout");
        checkOutput("rst_restart_pc", insn_pc_o, RESET_PC);
        toNextCycle();
        stream(2);
`ifdef FETCH_STATS_EN
        toNegedge();
        checkOutput("stats_count", fetch_count_o, 32'(popCount - popBase));
        toNextCycle();
`endif

        // PC wrap across the top of the address space.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
        toNegedge();
        toNextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        fillQueue(32'hFFFF_FFF8);
        mark = popCount;
        stream(6);
        checkOutput("wrap_pops", 32'(popCount - mark), 32'd4);
        toNegedge();
        checkOutput("wrap_next_pc", insn_pc_o, 32'h0000_0008);
        toNextCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
